// File: rtl/apple_placer.sv
// apple_placer: picks a pseudo-random start cell, then walks the field one cell per clock with wrap-around.
// Optional macro APPLE_PLACER_SEED_EN adds i_seed_load/i_seed to reload the LFSR.
module apple_placer #(
    parameter  int SIZE_X     = 10,
    parameter  int SIZE_Y     = 10,
    parameter  int CELL_BITS  = 3,
    parameter  int EMPTY_CODE = 0,
    localparam int N          = SIZE_X * SIZE_Y,
    localparam int FIELD_SIZE = N * CELL_BITS,
    localparam int SBITS      = $clog2(N),
    localparam int POSBITS    = $clog2(FIELD_SIZE)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic [FIELD_SIZE-1:0] i_field,
`ifdef APPLE_PLACER_SEED_EN
    input  logic                  i_seed_load,
    input  logic [15:0]           i_seed,
`endif
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_full,
    output logic [POSBITS-1:0]    o_apple_pos
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [15:0]      LFSR_RESET = 16'hACE1;
    localparam logic [15:0]      LFSR_MASK  = 16'hB400;
    localparam logic [SBITS-1:0] LAST_IDX   = SBITS'(N - 1);

    state_t             r_state;
    logic [15:0]        r_lfsr;
    logic [SBITS-1:0]   r_idx;
    logic [SBITS-1:0]   r_count;
    logic               r_busy;
    logic               r_done;
    logic               r_full;
    logic [POSBITS-1:0] r_apple_pos;

    state_t             w_state_nxt;
    logic [15:0]        w_lfsr_nxt;
    logic [SBITS-1:0]   w_idx_nxt;
    logic [SBITS-1:0]   w_count_nxt;
    logic               w_done_nxt;
    logic               w_full_nxt;
    logic [POSBITS-1:0] w_pos_nxt;

    logic [SBITS-1:0]     w_start_raw;
    logic [SBITS-1:0]     w_start;
    logic [CELL_BITS-1:0] w_cell;
    logic                 w_hit;
    logic [POSBITS-1:0]   w_pos;

    // Single conditional subtract is enough because 2^SBITS < 2*N.
    assign w_start_raw = r_lfsr[SBITS-1:0];
    assign w_start     = (w_start_raw > LAST_IDX) ? (w_start_raw - SBITS'(N)) : w_start_raw;
    assign w_cell      = i_field[int'(r_idx) * CELL_BITS +: CELL_BITS];
    assign w_hit       = (w_cell == CELL_BITS'(EMPTY_CODE));
    assign w_pos       = POSBITS'(r_idx) * POSBITS'(CELL_BITS);

    // LFSR next value: optional seed load wins over the free-running Galois shift.
    always_comb begin
        w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
`ifdef APPLE_PLACER_SEED_EN
        if (i_seed_load) begin
            w_lfsr_nxt = (i_seed == 16'h0000) ? LFSR_RESET : i_seed;
        end else begin
            w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
        end
`endif
    end

    // Next-state and result logic of the search FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        w_full_nxt  = 1'b0;
        w_pos_nxt   = r_apple_pos;
        case (r_state)
            ST_IDLE: begin
                // The done cycle is still IDLE but must not accept a new request.
                if (i_req && !r_done) begin
                    w_state_nxt = ST_SCAN;
                    w_idx_nxt   = w_start;
                    w_count_nxt = {SBITS{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (w_hit) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_full_nxt  = 1'b0;
                    w_pos_nxt   = w_pos;
                end else if (r_count == LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_full_nxt  = 1'b1;
                end else begin
                    w_idx_nxt   = (r_idx == LAST_IDX) ? {SBITS{1'b0}} : (r_idx + SBITS'(1));
                    w_count_nxt = r_count + SBITS'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= LFSR_RESET;
            r_idx       <= {SBITS{1'b0}};
            r_count     <= {SBITS{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_full      <= 1'b0;
            r_apple_pos <= {POSBITS{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_lfsr      <= w_lfsr_nxt;
            r_idx       <= w_idx_nxt;
            r_count     <= w_count_nxt;
            r_busy      <= (w_state_nxt == ST_SCAN);
            r_done      <= w_done_nxt;
            r_full      <= w_full_nxt;
            r_apple_pos <= w_pos_nxt;
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_full      = r_full;
    assign o_apple_pos = r_apple_pos;

endmodule

// File: tb/tb_apple_placer.sv
// Directed self-checking bench for apple_placer (10x10 board, 3-bit cells).
module tb_apple_placer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic [299:0] field = '0;
    logic         seed_load = 1'b0;
    logic [15:0]  seed = 16'h0000;
    logic         busy;
    logic         done;
    logic         full;
    logic [8:0]   apple_pos;

    int checks = 0;
    int passes = 0;
    logic [15:0] m_lfsr;

    apple_placer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_field     (field),
`ifdef APPLE_PLACER_SEED_EN
        .i_seed_load (seed_load),
        .i_seed      (seed),
`endif
        .o_busy      (busy),
        .o_done      (done),
        .o_full      (full),
        .o_apple_pos (apple_pos)
    );

    always #5 clk = ~clk;

    // Reference LFSR, stepped independently of the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= 16'hACE1;
`ifdef APPLE_PLACER_SEED_EN
        end else if (seed_load) begin
            m_lfsr <= (seed == 16'h0000) ? 16'hACE1 : seed;
`endif
        end else begin
            m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int start_of(input logic [15:0] l);
        int s;
        s = int'(l[6:0]);
        if (s >= 100) s = s - 100;
        return s;
    endfunction

    task automatic set_all(input logic [2:0] v);
        for (int i = 0; i < 100; i++) field[i*3 +: 3] = v;
    endtask

    // Waits until done is seen at a negedge; cyc counts edges after the accepting edge.
    task automatic wait_done(input int max, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < max) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
        end
    endtask

    // Raises req before edge 0 and returns the start cell the DUT should use.
    task automatic issue_req(input bit hold, output int start);
        req = 1'b1;
        start = start_of(m_lfsr);
        @(posedge clk);
        @(negedge clk);
        if (!hold) req = 1'b0;
    endtask

    initial begin
        int  start;
        int  cyc;
        bit  got;
        int  pulses;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_full", full, 0);
        check("reset_pos", apple_pos, 0);

        // 1. Reset in the middle of a full-board scan
        set_all(3'd1);
        issue_req(1'b0, start);
        repeat (20) @(negedge clk);
        check("t1_busy_mid", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t1_rst_busy", busy, 0);
        check("t1_rst_done", done, 0);
        check("t1_rst_full", full, 0);
        check("t1_rst_pos", apple_pos, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("t1_no_done", pulses, 0);

        // 2. Only cell 57 empty
        set_all(3'd1);
        field[57*3 +: 3] = 3'd0;
        issue_req(1'b0, start);
        check("t2_busy", busy, 1);
        wait_done(100, cyc, got);
        check("t2_got_done", got, 1);
        check("t2_latency", cyc, ((57 - start + 100) % 100) + 1);
        check("t2_pos", apple_pos, 171);
        check("t2_full", full, 0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("t2_single_pulse", pulses, 0);

        // 3. Full board: done at edge 100, apple_pos kept
        set_all(3'd1);
        issue_req(1'b0, start);
        wait_done(120, cyc, got);
        check("t3_got_done", got, 1);
        check("t3_latency", cyc, 100);
        check("t3_full", full, 1);
        check("t3_pos_kept", apple_pos, 171);
        @(negedge clk);
        check("t3_full_cleared", full, 0);
        check("t3_done_cleared", done, 0);

`ifdef APPLE_PLACER_SEED_EN
        // 4. Seed start 95, only cell 2 empty: wraps through 99 -> 0
        seed_load = 1'b1;
        seed = 16'h3A5F;
        @(negedge clk);
        seed_load = 1'b0;
        set_all(3'd2);
        field[2*3 +: 3] = 3'd0;
        issue_req(1'b0, start);
        wait_done(100, cyc, got);
        check("t4_got_done", got, 1);
        check("t4_latency", cyc, 8);
        check("t4_pos", apple_pos, 6);
        check("t4_full", full, 0);
        @(negedge clk);

        // 5. Seed low bits 110 -> start 10; cells 10 and 11 empty
        seed_load = 1'b1;
        seed = 16'h00EE;
        @(negedge clk);
        seed_load = 1'b0;
        set_all(3'd4);
        field[10*3 +: 3] = 3'd0;
        field[11*3 +: 3] = 3'd0;
        issue_req(1'b0, start);
        wait_done(100, cyc, got);
        check("t5_got_done", got, 1);
        check("t5_latency", cyc, 1);
        check("t5_pos", apple_pos, 30);
        @(negedge clk);
`endif

        // 6. req held high, only cell 0 empty
        set_all(3'd3);
        field[2:0] = 3'd0;
        issue_req(1'b1, start);
        for (int r = 0; r < 3; r++) begin
            check("t6_busy", busy, 1);
            wait_done(100, cyc, got);
            check("t6_got_done", got, 1);
            check("t6_latency", cyc, ((100 - start) % 100) + 1);
            check("t6_pos", apple_pos, 0);
            check("t6_full", full, 0);
            @(negedge clk);
            check("t6_gap_busy", busy, 0);
            check("t6_gap_done", done, 0);
            start = start_of(m_lfsr);
            @(negedge clk);
        end
        req = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
